// File: rtl/gpio_input_capture_pkg.sv
// Shared definitions for the GPIO input-capture block: register byte offsets
// and the INIT/RUN sequencing state type.
package gpio_input_capture_pkg;

  localparam logic [7:0] ADDR_LEVEL    = 8'h00;
  localparam logic [7:0] ADDR_RISE_EN  = 8'h04;
  localparam logic [7:0] ADDR_FALL_EN  = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h10;
  localparam logic [7:0] ADDR_DEBOUNCE = 8'h14;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/gpio_in_debounce.sv
// One input pin: synchroniser chain, debounce counter, debounced level and
// its one-cycle-delayed copy used for edge detection.
module gpio_in_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DBC_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DBC_W-1:0] dbc_n,
  input  logic             pin,
  output logic             stable,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBC_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   stable_d_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronise the pin, then accept a new level only after it has differed
  // from the current one for dbc_n+1 consecutive cycles. While not running,
  // the level tracks the synchroniser so no edge is seen at start-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (!run) begin
        stable_q   <= s;
        stable_d_q <= s;
        cnt_q      <= '0;
      end else begin
        stable_d_q <= stable_q;
        if (s != stable_q) begin
          // >= rather than == so a DEBOUNCE lowered mid-count still resolves
          if (cnt_q >= dbc_n) begin
            stable_q <= s;
            cnt_q    <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + DBC_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_d_q;
  assign fall   = ~stable_q & stable_d_q;

endmodule

// File: rtl/gpio_input_capture.sv
// GPIO input capture: per-pin debounce, edge capture into a W1C status
// register, masked level interrupt, and a small memory-mapped register file.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | first SYNC_STAGES+1 cycles after reset; levels track the
//         | synchronisers directly and edge capture is masked
// ST_RUN  | normal debounce and edge capture until the next reset
module gpio_input_capture
  import gpio_input_capture_pkg::*;
#(
  parameter int               NUM_PINS    = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               DBC_W       = 16,
  parameter logic [DBC_W-1:0] DBC_RESET   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  input  logic                we,
  input  logic                re,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic                irq
);

  localparam logic [7:0] INIT_LAST = 8'(SYNC_STAGES);

  cap_state_e          state_q;
  logic [7:0]          init_cnt_q;
  logic                run_q;

  logic [NUM_PINS-1:0] rise_en_q;
  logic [NUM_PINS-1:0] fall_en_q;
  logic [NUM_PINS-1:0] irq_en_q;
  logic [NUM_PINS-1:0] status_q;
  logic [NUM_PINS-1:0] status_d;
  logic [NUM_PINS-1:0] w1c;
  logic [DBC_W-1:0]    debounce_q;
  logic                irq_q;

  logic [NUM_PINS-1:0] stable;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;

  // Reads have no side effects, so re and the unused write bits go nowhere.
  logic unused_bus;
  assign unused_bus = ^{re, write_data};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_in_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DBC_W       (DBC_W)
    ) u_dbc (
      .clk    (clk),
      .rst    (rst),
      .run    (run_q),
      .dbc_n  (debounce_q),
      .pin    (gpio_in[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // INIT holds for SYNC_STAGES+1 cycles so the synchronisers fill before capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          run_q   <= 1'b1;
        end
      endcase
    end
  end

  // W1C clear first, then OR in new edges so a simultaneous set wins.
  always_comb begin
    w1c = '0;
    if (we && (address == ADDR_STATUS)) w1c = write_data[NUM_PINS-1:0];
    status_d = status_q & ~w1c;
    if (run_q) status_d = status_d | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Bus-writable configuration registers; writes are honoured in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_en_q   <= '0;
      debounce_q <= DBC_RESET;
    end else if (we) begin
      case (address)
        ADDR_RISE_EN:  rise_en_q  <= write_data[NUM_PINS-1:0];
        ADDR_FALL_EN:  fall_en_q  <= write_data[NUM_PINS-1:0];
        ADDR_IRQ_EN:   irq_en_q   <= write_data[NUM_PINS-1:0];
        ADDR_DEBOUNCE: debounce_q <= write_data[DBC_W-1:0];
        default: ;
      endcase
    end
  end

  // Status capture and the interrupt flop one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |(status_q & irq_en_q);
    end
  end

  assign irq = irq_q;

  // Read mux; unmapped addresses and unused upper bits return zero.
  always_comb begin
    read_data = '0;
    case (address)
      ADDR_LEVEL:    read_data[NUM_PINS-1:0] = stable;
      ADDR_RISE_EN:  read_data[NUM_PINS-1:0] = rise_en_q;
      ADDR_FALL_EN:  read_data[NUM_PINS-1:0] = fall_en_q;
      ADDR_STATUS:   read_data[NUM_PINS-1:0] = status_q;
      ADDR_IRQ_EN:   read_data[NUM_PINS-1:0] = irq_en_q;
      ADDR_DEBOUNCE: read_data[DBC_W-1:0]    = debounce_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Bench for gpio_input_capture: directed scenarios plus randomized pin
// activity and bus traffic, checked every cycle against a behavioural model.
module tb_gpio_input_capture;
  import gpio_input_capture_pkg::*;

  localparam int NP = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [NP-1:0] gpio_in = 8'hFF;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  gpio_input_capture #(
    .NUM_PINS(NP), .SYNC_STAGES(SS), .DBC_W(16), .DBC_RESET(16'd0)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_data(read_data), .we(we), .re(re), .gpio_in(gpio_in), .irq(irq)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  hist[$];          // raw samples; hist[0] is what the core sees
  logic [7:0]  m_level = '0, m_prev = '0, m_status = '0;
  logic [7:0]  m_ren = '0, m_fen = '0, m_ien = '0;
  logic [15:0] m_dbc = '0;
  logic        m_irq = 1'b0;
  int          run_len[NP];      // consecutive cycles the seen input disagreed
  int          since_rst = 0;
  logic [7:0]  m_s, m_clr, m_stat_n, lvl_n, prev_n;
  logic        m_init, m_irq_n;

  initial for (int i = 0; i < SS; i++) hist.push_back(8'h00);

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(8'h00);
      m_level = '0; m_prev = '0; m_status = '0;
      m_ren = '0; m_fen = '0; m_ien = '0; m_dbc = '0; m_irq = 1'b0;
      since_rst = 0;
      for (int i = 0; i < NP; i++) run_len[i] = 0;
    end else begin
      m_s     = hist[0];
      m_init  = (since_rst < SS + 1);
      m_irq_n = |(m_status & m_ien);
      m_clr   = (we && address == ADDR_STATUS) ? write_data[7:0] : 8'h00;
      m_stat_n = m_status & ~m_clr;
      if (!m_init)
        m_stat_n = m_stat_n | (m_level & ~m_prev & m_ren) | (~m_level & m_prev & m_fen);
      if (m_init) begin
        lvl_n = m_s; prev_n = m_s;
        for (int i = 0; i < NP; i++) run_len[i] = 0;
      end else begin
        prev_n = m_level; lvl_n = m_level;
        for (int i = 0; i < NP; i++) begin
          if (m_s[i] != m_level[i]) begin
            run_len[i]++;
            if (run_len[i] > int'(m_dbc)) begin
              lvl_n[i] = m_s[i];
              run_len[i] = 0;
            end
          end else begin
            run_len[i] = 0;
          end
        end
      end
      if (we) begin
        case (address)
          ADDR_RISE_EN:  m_ren = write_data[7:0];
          ADDR_FALL_EN:  m_fen = write_data[7:0];
          ADDR_IRQ_EN:   m_ien = write_data[7:0];
          ADDR_DEBOUNCE: m_dbc = write_data[15:0];
          default: ;
        endcase
      end
      m_level = lvl_n; m_prev = prev_n; m_status = m_stat_n; m_irq = m_irq_n;
      hist.push_back(gpio_in);
      void'(hist.pop_front());
      if (since_rst < 1000) since_rst++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    address = a;
    re = 1'b1;
    #1;
    d = read_data;
  endtask

  task automatic verify();
    logic [31:0] d;
    we = 1'b0;
    rd(ADDR_LEVEL, d);    chk("level", d, {24'h0, m_level});
    rd(ADDR_STATUS, d);   chk("status", d, {24'h0, m_status});
    rd(ADDR_RISE_EN, d);  chk("rise_en", d, {24'h0, m_ren});
    rd(ADDR_FALL_EN, d);  chk("fall_en", d, {24'h0, m_fen});
    rd(ADDR_IRQ_EN, d);   chk("irq_en", d, {24'h0, m_ien});
    rd(ADDR_DEBOUNCE, d); chk("debounce", d, {16'h0, m_dbc});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    verify();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; address = a; write_data = d;
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int p, r, sel;

    // Reset with all pins high; no spurious rising edge after release.
    rst = 1'b1; gpio_in = 8'hFF;
    idle(2);
    rst = 1'b0;
    idle(2);
    rd(ADDR_LEVEL, d); chk("init_level_early", d, 32'h00);
    cyc();
    rd(ADDR_LEVEL, d); chk("init_level", d, 32'hFF);
    idle(5);
    rd(ADDR_STATUS, d); chk("init_status", d, 32'h00);
    chk("init_irq", {31'h0, irq}, 32'h0);

    // Rising edge on pin 0 with no debounce: STATUS at E+3, irq at E+4.
    wr(ADDR_DEBOUNCE, 32'd0);
    wr(ADDR_RISE_EN, 32'h01);
    wr(ADDR_IRQ_EN, 32'h01);
    gpio_in = 8'hFE;
    idle(6);
    gpio_in = 8'hFF;
    cyc();                               // edge E
    idle(2);
    rd(ADDR_STATUS, d); chk("rise0_status_e2", d, 32'h00);
    cyc();
    rd(ADDR_STATUS, d); chk("rise0_status_e3", d, 32'h01);
    chk("rise0_irq_e3", {31'h0, irq}, 32'h0);
    cyc();
    chk("rise0_irq_e4", {31'h0, irq}, 32'h1);
    wr(ADDR_STATUS, 32'h01);
    rd(ADDR_STATUS, d); chk("w1c_status", d, 32'h00);
    cyc();
    chk("w1c_irq", {31'h0, irq}, 32'h0);

    // Debounce 4: a 4-cycle glitch is ignored, a long pulse lands at E+6.
    wr(ADDR_DEBOUNCE, 32'd4);
    wr(ADDR_RISE_EN, 32'h09);
    gpio_in = 8'hF7;
    idle(10);
    gpio_in = 8'hFF;
    idle(4);
    gpio_in = 8'hF7;
    idle(8);
    rd(ADDR_LEVEL, d);  chk("glitch_level", d & 32'h08, 32'h00);
    rd(ADDR_STATUS, d); chk("glitch_status", d, 32'h00);
    gpio_in = 8'hFF;
    cyc();                               // edge E
    idle(5);
    rd(ADDR_LEVEL, d);  chk("dbc_level_e5", d & 32'h08, 32'h00);
    cyc();
    rd(ADDR_LEVEL, d);  chk("dbc_level_e6", d & 32'h08, 32'h08);
    idle(2);
    wr(ADDR_STATUS, 32'hFF);

    // Falling-only capture on pin 7; reads do not disturb STATUS.
    wr(ADDR_DEBOUNCE, 32'd0);
    wr(ADDR_RISE_EN, 32'h00);
    wr(ADDR_FALL_EN, 32'h80);
    gpio_in = 8'h7F;
    idle(4);
    gpio_in = 8'hFF;
    idle(4);
    rd(ADDR_STATUS, d); chk("fall7_status", d, 32'h80);
    cyc();
    rd(ADDR_STATUS, d); chk("fall7_reread", d, 32'h80);
    wr(ADDR_STATUS, 32'h80);

    // Write to read-only LEVEL is ignored (model compares on the next verify).
    wr(ADDR_LEVEL, 32'h00);
    rd(ADDR_LEVEL, d); chk("level_ro", d, 32'hFF);

    // W1C and a new rising edge on pin 2 in the same cycle: set wins.
    wr(ADDR_FALL_EN, 32'h00);
    wr(ADDR_RISE_EN, 32'h04);
    gpio_in = 8'hFB;
    idle(4);
    gpio_in = 8'hFF;
    cyc();                               // edge E
    idle(2);
    wr(ADDR_STATUS, 32'h04);             // lands on edge E+3
    rd(ADDR_STATUS, d); chk("set_wins", d & 32'h04, 32'h04);
    wr(ADDR_STATUS, 32'h04);
    rd(ADDR_STATUS, d); chk("clr_after", d & 32'h04, 32'h00);

    // Reset while pin 5 is mid-debounce with STATUS=0x20 pending.
    wr(ADDR_DEBOUNCE, 32'd4);
    wr(ADDR_RISE_EN, 32'h20);
    wr(ADDR_IRQ_EN, 32'h20);
    gpio_in = 8'hDF;
    idle(8);
    gpio_in = 8'hFF;
    idle(10);
    rd(ADDR_STATUS, d); chk("pre_rst_status", d, 32'h20);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    gpio_in = 8'hDF;
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    rd(ADDR_RISE_EN, d);  chk("rst_rise_en", d, 32'h0);
    rd(ADDR_FALL_EN, d);  chk("rst_fall_en", d, 32'h0);
    rd(ADDR_STATUS, d);   chk("rst_status", d, 32'h0);
    rd(ADDR_IRQ_EN, d);   chk("rst_irq_en", d, 32'h0);
    rd(ADDR_DEBOUNCE, d); chk("rst_debounce", d, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    idle(10);
    rd(ADDR_STATUS, d);   chk("post_rst_status", d, 32'h0);
    rd(ADDR_LEVEL, d);    chk("post_rst_level", d, 32'hDF);
    rd(8'h18, d);         chk("unmapped_0x18", d, 32'h0);

    // Randomized pin activity, configuration and W1C traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        p = $urandom_range(0, NP - 1);
        gpio_in[p] = ~gpio_in[p];
      end
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
      end else if (r < 30) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: wr(ADDR_RISE_EN, $urandom);
          1: wr(ADDR_FALL_EN, $urandom);
          2: wr(ADDR_IRQ_EN, $urandom);
          3: wr(ADDR_STATUS, $urandom);
          4: wr(ADDR_DEBOUNCE, 32'($urandom_range(0, 6)));
          default: wr(8'h18, $urandom);
        endcase
      end else begin
        cyc();
      end
    end
    rd(8'h1C, d); chk("unmapped_0x1c", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
